xor_gate_checker: RTL and testbench
===================================

# xor_gate_checker

Synthesizable stimulus-and-check engine for a 2-input XOR gate with propagation delay. On a START request it drives the gate inputs through all four input combinations, waits a parameterised settle interval per vector, samples the gate output, compares it against A^B, and reports pass/fail, an error count and the first failing vector. It connects directly to an `xor_gate_delay` instance (A, B in; X out) and is the on-chip counterpart of the simulation-only stimulus bench for that gate.

## Interface
- SETTLE_CYCLES, 4, clock cycles each vector is held before X is sampled (>=1); SETTLE_CYCLES x clock period must exceed the DUT propagation delay
- LOOPS, 1, passes through the 4-vector sequence per run (>=1)
- ERR_W, 8, width of ERR_CNT
- CLK  in  1  clock, rising edge; the only clock
- RST_N  in  1  reset, asynchronous, active-low
- START  in  1  run request, sampled only in IDLE
- A  out  1  DUT input A
- B  out  1  DUT input B
- X  in  1  DUT output
- BUSY  out  1  high while a run is in progress
- DONE  out  1  one-cycle pulse at end of run
- PASS  out  1  1 = last run had zero mismatches; held until next START accepted
- ERR_CNT  out  ERR_W  mismatch count of last/current run, saturating
- FAIL_VEC  out  2  {A,B} of first mismatch in run
- FAIL_VLD  out  1  FAIL_VEC holds a captured mismatch

## Operation
- Reset values: A=0, B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=2'b00, FAIL_VLD=0; state IDLE.
- States: IDLE, SETTLE, DONE.
- IDLE: START=1 at an edge -> state SETTLE, {A,B}<=2'b00, BUSY<=1, settle counter loaded, vector index 0, loop count 0, ERR_CNT/FAIL_VLD/FAIL_VEC/PASS cleared.
- Vector order per loop, as {A,B}: 00, 10, 01, 11.
- SETTLE: counter decrements each edge; at the edge ending the SETTLE_CYCLES-th cycle after {A,B} changed, X is sampled and compared to A^B.
  - Mismatch: ERR_CNT+1 (saturate at 2^ERR_W-1); if FAIL_VLD=0, FAIL_VEC<={A,B}, FAIL_VLD<=1.
  - Same edge: if more vectors remain, {A,B}<=next vector (wrapping 11->00 and incrementing loop count between loops), counter reloaded; else state DONE, {A,B}<=00, BUSY<=0, DONE<=1, PASS<=(no mismatch in whole run, including the final sample).
- DONE: lasts exactly one cycle; START ignored; next edge -> IDLE, DONE<=0.
- START while BUSY or in DONE: ignored, no effect on run.
- RST_N low at any time: all outputs and state to reset values immediately, no DONE pulse; run abandoned.

## Timing
- All outputs registered; change only on CLK rising edge or RST_N falling.
- A/B valid the cycle after the START-accepting edge.
- Each vector held exactly SETTLE_CYCLES cycles.
- DONE high in the cycle following edge N = 4 x LOOPS x SETTLE_CYCLES counted from the START-accepting edge; BUSY high for exactly N cycles.
- Earliest next accepted START: edge ending the DONE cycle +1 (i.e. first IDLE cycle); back-to-back START held high gives runs separated by one DONE cycle.
- X sampled with no synchronizer; DUT is combinational from A/B, so sampling is synchronous provided the settle rule holds.

## Test plan
- Good DUT (X=A^B, #1 ns, CLK 10 ns, SETTLE_CYCLES=4, LOOPS=1), 1-cycle START -> BUSY 16 cycles, {A,B}=00,10,01,11 each 4 cycles, DONE pulse 16 edges after accept, PASS=1, ERR_CNT=0, FAIL_VLD=0, {A,B}=00 after.
- DUT replaced by X=A|B -> ERR_CNT=1, FAIL_VEC=2'b11, FAIL_VLD=1, PASS=0.
- DUT X stuck-at-0 -> mismatches at 10 and 01, ERR_CNT=2, FAIL_VEC=2'b10, PASS=0.
- LOOPS=3, ERR_W=2, X stuck-at-1 -> 6 mismatches, ERR_CNT saturates at 2'b11, FAIL_VEC=2'b00, DONE 48 edges after accept.
- START pulsed during BUSY -> no restart, DONE at original time; START held high -> second run accepted the cycle after DONE, ERR_CNT/PASS/FAIL_VLD cleared at that edge.
- RST_N low 7 cycles into a run -> all outputs 0 asynchronously, no DONE; after release, fresh START completes with PASS=1 on good DUT.

Source files
------------

// File: rtl/xor_gate_checker.sv
// xor_gate_checker: drives a 2-input XOR DUT through all vectors, checks X against A^B and reports the result
module xor_gate_checker #(
   parameter int SETTLE_CYCLES = 4,
   parameter int LOOPS         = 1,
   parameter int ERR_W         = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   output logic             a_o,
   output logic             b_o,
   input  logic             x_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [ERR_W-1:0] err_cnt_o,
   output logic [1:0]       fail_vec_o,
   output logic             fail_vld_o
);
   localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
   localparam int LW = LOOPS > 1 ? $clog2(LOOPS) : 1;
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;
   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [1:0]       idx_q;
   logic [LW-1:0]    loop_q;
   logic             a_q, b_q, busy_q, done_q, pass_q, fail_vld_q;
   logic [ERR_W-1:0] err_q;
   logic [1:0]       fail_vec_q;
   logic             mis, last;
   logic [1:0]       idx_d;
   assign mis   = x_i != (a_q ^ b_q);
   assign last  = idx_q == 2'd3 && loop_q == LW'(LOOPS - 1);
   assign idx_d = idx_q + 2'd1;
   // index 0..3 maps to {A,B} = 00,10,01,11 by swapping the index bits
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         loop_q     <= '0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= '0;
         fail_vec_q <= 2'b00;
         fail_vld_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (start_i) begin
               state_q    <= S_SETTLE;
               a_q        <= 1'b0;
               b_q        <= 1'b0;
               busy_q     <= 1'b1;
               cnt_q      <= CW'(SETTLE_CYCLES - 1);
               idx_q      <= '0;
               loop_q     <= '0;
               err_q      <= '0;
               fail_vec_q <= 2'b00;
               fail_vld_q <= 1'b0;
               pass_q     <= 1'b0;
            end
            S_SETTLE: if (cnt_q != '0) begin
               cnt_q <= cnt_q - 1'b1;
            end else begin
               if (mis) begin
                  err_q <= err_q == '1 ? err_q : err_q + 1'b1;
                  if (!fail_vld_q) begin
                     fail_vec_q <= {a_q, b_q};
                     fail_vld_q <= 1'b1;
                  end
               end
               if (last) begin
                  state_q <= S_DONE;
                  a_q     <= 1'b0;
                  b_q     <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= !fail_vld_q && !mis;
               end else begin
                  idx_q <= idx_d;
                  a_q   <= idx_d[0];
                  b_q   <= idx_d[1];
                  cnt_q <= CW'(SETTLE_CYCLES - 1);
                  if (idx_q == 2'd3) loop_q <= loop_q + 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign a_o        = a_q;
   assign b_o        = b_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign pass_o     = pass_q;
   assign err_cnt_o  = err_q;
   assign fail_vec_o = fail_vec_q;
   assign fail_vld_o = fail_vld_q;
endmodule

// File: tb/tb_xor_gate_checker.sv
// tb_xor_gate_checker: scoreboard bench for the XOR gate checker with selectable faulty gate models
module tb_xor_gate_checker;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0;
   int   mode = 0;
   always #5 clk = ~clk;
   logic a0, b0, x0, busy0, done0, pass0, fvld0;
   logic [7:0] err0;
   logic [1:0] fvec0;
   logic a1, b1, x1, busy1, done1, pass1, fvld1;
   logic [1:0] err1;
   logic [1:0] fvec1;
   // gate models: 0 good XOR, 1 OR, 2 stuck-at-0, 3 stuck-at-1
   function automatic logic fx(input int m, input logic a, input logic b);
      return m == 0 ? a ^ b : m == 1 ? a | b : m == 2 ? 1'b0 : 1'b1;
   endfunction
   assign x0 = fx(mode, a0, b0);
   assign x1 = fx(mode, a1, b1);
   xor_gate_checker #(.SETTLE_CYCLES(4), .LOOPS(1), .ERR_W(8)) u0 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start & !sel), .a_o(a0), .b_o(b0), .x_i(x0),
      .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_cnt_o(err0),
      .fail_vec_o(fvec0), .fail_vld_o(fvld0));
   xor_gate_checker #(.SETTLE_CYCLES(4), .LOOPS(3), .ERR_W(2)) u1 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start & sel), .a_o(a1), .b_o(b1), .x_i(x1),
      .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_cnt_o(err1),
      .fail_vec_o(fvec1), .fail_vld_o(fvld1));
   logic oa, ob, obusy, odone, opass, ofvld;
   logic [7:0] oerr;
   logic [1:0] ofvec;
   assign oa    = sel ? a1 : a0;
   assign ob    = sel ? b1 : b0;
   assign obusy = sel ? busy1 : busy0;
   assign odone = sel ? done1 : done0;
   assign opass = sel ? pass1 : pass0;
   assign ofvld = sel ? fvld1 : fvld0;
   assign oerr  = sel ? {6'b0, err1} : err0;
   assign ofvec = sel ? fvec1 : fvec0;
   int n_chk = 0, n_err = 0;
   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
      end
   endtask
   typedef struct {logic pass; int err; logic [1:0] fvec; logic fvld;} res_t;
   res_t       rq[$];
   logic [1:0] vq[$];
   task automatic run(input bit hold, input int glitch);
      int loops, sat, n;
      res_t r;
      logic [1:0] ord [4];
      logic [1:0] v;
      ord   = '{2'b00, 2'b10, 2'b01, 2'b11};
      loops = sel ? 3 : 1;
      sat   = sel ? 3 : 255;
      r     = '{1'b0, 0, 2'b00, 1'b0};
      for (int l = 0; l < loops; l++)
         for (int k = 0; k < 4; k++) begin
            v = ord[k];
            repeat (4) vq.push_back(v);
            if (fx(mode, v[1], v[0]) != (v[1] ^ v[0])) begin
               if (r.err < sat) r.err++;
               if (!r.fvld) begin
                  r.fvec = v;
                  r.fvld = 1'b1;
               end
            end
         end
      r.pass = !r.fvld;
      rq.push_back(r);
      n = 16 * loops;
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      chk("clr_pass", opass, 0);
      chk("clr_err", oerr, 0);
      chk("clr_fvld", ofvld, 0);
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         if (i == glitch) start = 1'b1;
         else if (i == glitch + 1 && !hold) start = 1'b0;
         chk("ab", {oa, ob}, vq.pop_front());
         chk("busy", obusy, 1);
         chk("done_early", odone, 0);
      end
      @(negedge clk);
      r = rq.pop_front();
      chk("done", odone, 1);
      chk("busy_end", obusy, 0);
      chk("ab_end", {oa, ob}, 0);
      chk("pass", opass, r.pass);
      chk("err_cnt", oerr, r.err);
      chk("fail_vec", ofvec, r.fvec);
      chk("fail_vld", ofvld, r.fvld);
      @(negedge clk);
      chk("done_pulse", odone, 0);
      chk("busy_idle", obusy, 0);
      chk("pass_held", opass, r.pass);
      chk("ab_idle", {oa, ob}, 0);
   endtask
   initial begin
      #3;
      chk("rst_ab0", {a0, b0}, 0);
      chk("rst_busy0", busy0, 0);
      chk("rst_done0", done0, 0);
      chk("rst_pass0", pass0, 0);
      chk("rst_err0", err0, 0);
      chk("rst_fvec0", fvec0, 0);
      chk("rst_fvld0", fvld0, 0);
      chk("rst_busy1", busy1, 0);
      chk("rst_err1", err1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mode = 0; run(1'b0, -1);
      mode = 1; run(1'b0, -1);
      mode = 2; run(1'b0, -1);
      sel = 1'b1; mode = 3; run(1'b0, -1);
      sel = 1'b0; mode = 0; run(1'b0, 5);
      mode = 1; run(1'b1, -1);
      mode = 0; run(1'b1, -1);
      start = 1'b0;
      repeat (2) @(negedge clk);
      mode = 3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_rst_fvld", fvld0, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ab", {a0, b0}, 0);
      chk("arst_busy", busy0, 0);
      chk("arst_err", err0, 0);
      chk("arst_fvld", fvld0, 0);
      chk("arst_fvec", fvec0, 0);
      chk("arst_done", done0, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      mode = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("no_done", done0, 0);
         chk("no_busy", busy0, 0);
      end
      run(1'b0, -1);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
